// File: rtl/controle_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: instruction
// field encodings, FSM states, ULA input select codes and the op decoder.
package controle_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_DWORD  = 3'b011;
    localparam logic [2:0] F3_ADD    = 3'b000;

    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    // ULA input select codes
    localparam logic [1:0] ENT_B = 2'd0;
    localparam logic [1:0] ENT_A = 2'd1;
    localparam logic [1:0] ENT_C = 2'd2;

    typedef enum logic [2:0] {
        OCIOSO,
        DECODIFICA,
        EXECUTA,
        MEMORIA,
        ESCRITA,
        RETIRA,
        ERRO
    } estado_t;

    typedef enum logic [2:0] {
        OP_LD,
        OP_SD,
        OP_ADD,
        OP_SUB,
        OP_ADDI,
        OP_ILEGAL
    } op_t;

    // Maps an instruction word onto one of the supported operations.
    function automatic op_t decodifica(input logic [31:0] w);
        op_t op;
        op = OP_ILEGAL;
        case (w[6:0])
            OPC_LOAD:  if (w[14:12] == F3_DWORD) op = OP_LD;
            OPC_STORE: if (w[14:12] == F3_DWORD) op = OP_SD;
            OPC_OP: begin
                if (w[14:12] == F3_ADD) begin
                    if (w[31:25] == F7_ADD)      op = OP_ADD;
                    else if (w[31:25] == F7_SUB) op = OP_SUB;
                end
            end
            OPC_OPIMM: if (w[14:12] == F3_ADD) op = OP_ADDI;
            default:   op = OP_ILEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/gerador_imediato.sv
// Extracts the I- or S-type immediate of an instruction and sign-extends it
// to the datapath width. R-type and unknown opcodes yield zero.
module gerador_imediato
    import controle_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic unused_bits;
    assign unused_bits = ^instr[19:12];

    // Immediate format is chosen by opcode alone.
    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            OPC_STORE:           imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            default:             imm = '0;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit for the ld/sd/add/sub/addi RISC-V datapath.
// Every output is registered: each state's combinational decision is
// captured on the edge that leaves that state, so a state's effects are
// visible during the cycle after it.
module unidade_controle_multiciclo
    import controle_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] PC_RESET = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [4:0]      Ra,
    output logic [4:0]      Rb,
    output logic [4:0]      Rw,
    output logic            WeR,
    output logic            WeM,
    output logic [XLEN-1:0] constante,
    output logic            soma_ou_subtrai,
    output logic            subtraindo,
    output logic [1:0]      escolhe_entrada1,
    output logic [1:0]      escolhe_entrada2,
    output logic            sel_dinR,
    output logic [XLEN-1:0] pc,
    output logic            done,
    output logic            illegal
);

    localparam logic [XLEN-1:0] PASSO = XLEN'(PC_STEP);

    estado_t         estado, prox_estado;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] imm;
    op_t             op;
    logic            aceita;

    logic            nx_ready;
    logic [4:0]      nx_ra, nx_rb, nx_rw;
    logic            nx_wer, nx_wem;
    logic [XLEN-1:0] nx_constante;
    logic            nx_soma, nx_sub;
    logic [1:0]      nx_e1, nx_e2;
    logic            nx_sel_din;
    logic [XLEN-1:0] nx_pc;
    logic            nx_done, nx_illegal;

    gerador_imediato #(.XLEN(XLEN)) u_imediato (
        .instr (instr_q),
        .imm   (imm)
    );

    assign op     = decodifica(instr_q);
    assign aceita = (estado == OCIOSO) && instr_valid && instr_ready;

    // State, latched instruction and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado           <= OCIOSO;
            instr_q          <= '0;
            instr_ready      <= 1'b1;
            Ra               <= '0;
            Rb               <= '0;
            Rw               <= '0;
            WeR              <= 1'b0;
            WeM              <= 1'b0;
            constante        <= '0;
            soma_ou_subtrai  <= 1'b0;
            subtraindo       <= 1'b0;
            escolhe_entrada1 <= '0;
            escolhe_entrada2 <= '0;
            sel_dinR         <= 1'b0;
            pc               <= PC_RESET;
            done             <= 1'b0;
            illegal          <= 1'b0;
        end else begin
            estado           <= prox_estado;
            if (aceita) instr_q <= instr;
            instr_ready      <= nx_ready;
            Ra               <= nx_ra;
            Rb               <= nx_rb;
            Rw               <= nx_rw;
            WeR              <= nx_wer;
            WeM              <= nx_wem;
            constante        <= nx_constante;
            soma_ou_subtrai  <= nx_soma;
            subtraindo       <= nx_sub;
            escolhe_entrada1 <= nx_e1;
            escolhe_entrada2 <= nx_e2;
            sel_dinR         <= nx_sel_din;
            pc               <= nx_pc;
            done             <= nx_done;
            illegal          <= nx_illegal;
        end
    end

    // Next state and next output values; selects hold, pulses default low.
    always_comb begin
        prox_estado  = estado;
        nx_ready     = 1'b0;
        nx_ra        = Ra;
        nx_rb        = Rb;
        nx_rw        = Rw;
        nx_wer       = 1'b0;
        nx_wem       = 1'b0;
        nx_constante = constante;
        nx_soma      = soma_ou_subtrai;
        nx_sub       = subtraindo;
        nx_e1        = escolhe_entrada1;
        nx_e2        = escolhe_entrada2;
        nx_sel_din   = sel_dinR;
        nx_pc        = pc;
        nx_done      = 1'b0;
        nx_illegal   = 1'b0;

        case (estado)
            OCIOSO: begin
                nx_ready = 1'b1;
                if (aceita) begin
                    nx_ready    = 1'b0;
                    prox_estado = DECODIFICA;
                end
            end
            DECODIFICA: begin
                // Clear everything left over from the previous instruction.
                nx_rb        = instr_q[19:15];
                nx_ra        = instr_q[24:20];
                nx_constante = imm;
                nx_rw        = '0;
                nx_soma      = 1'b0;
                nx_sub       = 1'b0;
                nx_e1        = ENT_B;
                nx_e2        = ENT_B;
                nx_sel_din   = 1'b0;
                prox_estado  = (op == OP_ILEGAL) ? ERRO : EXECUTA;
            end
            EXECUTA: begin
                nx_soma = 1'b1;
                nx_sub  = (op == OP_SUB);
                nx_e2   = ENT_B;
                nx_e1   = ((op == OP_ADD) || (op == OP_SUB)) ? ENT_A : ENT_C;
                case (op)
                    OP_SD: begin
                        nx_wem      = 1'b1;
                        prox_estado = RETIRA;
                    end
                    OP_LD:   prox_estado = MEMORIA;
                    default: prox_estado = ESCRITA;
                endcase
            end
            MEMORIA: begin
                nx_sel_din  = 1'b1;
                prox_estado = ESCRITA;
            end
            ESCRITA: begin
                nx_rw       = instr_q[11:7];
                nx_wer      = (instr_q[11:7] != 5'd0);
                prox_estado = RETIRA;
            end
            RETIRA: begin
                nx_done     = 1'b1;
                nx_pc       = pc + PASSO;
                prox_estado = OCIOSO;
            end
            ERRO: begin
                nx_illegal  = 1'b1;
                nx_pc       = pc + PASSO;
                prox_estado = OCIOSO;
            end
            default: prox_estado = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for the multi-cycle control unit: a vector table of instructions
// with expected controls and pulse timing, a scoreboard queue filled at
// handshake and drained at retire/illegal, and a small register-file /
// memory / ULA model driven by the DUT controls.
module tb_unidade_controle_multiciclo;
    import controle_pkg::*;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            instr_valid = 1'b0;
    logic [31:0]     instr = '0;
    logic            instr_ready;
    logic [4:0]      Ra, Rb, Rw;
    logic            WeR, WeM;
    logic [XLEN-1:0] constante;
    logic            soma_ou_subtrai, subtraindo;
    logic [1:0]      escolhe_entrada1, escolhe_entrada2;
    logic            sel_dinR;
    logic [XLEN-1:0] pc;
    logic            done, illegal;

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(
        .XLEN     (XLEN),
        .PC_RESET ('0),
        .PC_STEP  (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_ready      (instr_ready),
        .Ra               (Ra),
        .Rb               (Rb),
        .Rw               (Rw),
        .WeR              (WeR),
        .WeM              (WeM),
        .constante        (constante),
        .soma_ou_subtrai  (soma_ou_subtrai),
        .subtraindo       (subtraindo),
        .escolhe_entrada1 (escolhe_entrada1),
        .escolhe_entrada2 (escolhe_entrada2),
        .sel_dinR         (sel_dinR),
        .pc               (pc),
        .done             (done),
        .illegal          (illegal)
    );

    typedef struct {
        logic [31:0] w;
        bit          ileg;
        int          t_fim;   // cycles after handshake edge of done/illegal
        int          t_wer;   // -1 = never
        int          t_wem;   // -1 = never
        logic [4:0]  ra, rb, rw;
        logic [63:0] k;
        logic [1:0]  e1;
        bit          sub;
        bit          dinm;
    } vec_t;

    vec_t        vecs[9];
    vec_t        sb[$];
    logic [63:0] sb_pc[$];
    logic [63:0] regs[32];
    logic [63:0] mem[32];
    logic [63:0] pc_exp;
    int          errors = 0;
    int          checks = 0;

    function automatic vec_t mk(input logic [31:0] w, input bit ileg, input int t_fim,
                                input int t_wer, input int t_wem,
                                input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                                input logic [63:0] k, input logic [1:0] e1,
                                input bit sub, input bit dinm);
        vec_t v;
        v.w = w; v.ileg = ileg; v.t_fim = t_fim; v.t_wer = t_wer; v.t_wem = t_wem;
        v.ra = ra; v.rb = rb; v.rw = rw; v.k = k; v.e1 = e1; v.sub = sub; v.dinm = dinm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ent(input logic [1:0] s);
        case (s)
            ENT_B:   return regs[Rb];
            ENT_A:   return regs[Ra];
            ENT_C:   return constante;
            default: return '0;
        endcase
    endfunction

    function automatic logic [63:0] ula();
        logic [63:0] a, b;
        a = ent(escolhe_entrada1);
        b = ent(escolhe_entrada2);
        return subtraindo ? (b - a) : (b + a);
    endfunction

    task automatic run(input int i);
        vec_t        v, e;
        logic [63:0] pe, res;
        int          n, rel, fim_at, r_at, m_at, r_cnt, m_cnt;
        bit          fim, saw_done, saw_ileg;
        string       p;
        v = vecs[i];
        p = $sformatf("v%0d", i);
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (instr_ready !== 1'b1) begin
            chk({p, "_ready_timeout"}, 64'(instr_ready), 64'd1);
            return;
        end
        instr       = v.w;
        instr_valid = 1'b1;
        @(negedge clk);
        pc_exp = pc_exp + 64'd4;
        sb.push_back(v);
        sb_pc.push_back(pc_exp);
        // valid stays high with a junk word: the busy unit must ignore it
        instr = $urandom();
        chk({p, "_ready_drop"}, 64'(instr_ready), 64'd0);
        r_at = -1; m_at = -1; r_cnt = 0; m_cnt = 0;
        fim = 0; fim_at = -1; saw_done = 0; saw_ileg = 0;
        rel = 0;
        while (!fim && rel <= 12) begin
            if (rel > 0) @(negedge clk);
            res = ula();
            if (WeR && WeM) chk({p, "_wer_wem_excl"}, 64'd1, 64'd0);
            if (WeM) begin
                if (m_at < 0) m_at = rel;
                m_cnt++;
                mem[res[4:0]] = regs[Ra];
            end
            if (WeR) begin
                if (r_at < 0) r_at = rel;
                r_cnt++;
                if (Rw != 5'd0) regs[Rw] = sel_dinR ? mem[res[4:0]] : res;
            end
            if (done || illegal) begin
                fim = 1; fim_at = rel; saw_done = done; saw_ileg = illegal;
            end else begin
                rel++;
            end
        end
        instr_valid = 1'b0;
        e  = sb.pop_front();
        pe = sb_pc.pop_front();
        if (!fim) begin
            chk({p, "_finish_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({p, "_finish_cycle"}, 64'(fim_at), 64'(e.t_fim));
            chk({p, "_done_pulse"}, 64'(saw_done), 64'(!e.ileg));
            chk({p, "_illegal_pulse"}, 64'(saw_ileg), 64'(e.ileg));
            chk({p, "_wer_cycle"}, 64'(r_at), 64'(e.t_wer));
            chk({p, "_wem_cycle"}, 64'(m_at), 64'(e.t_wem));
            chk({p, "_wer_count"}, 64'(r_cnt), (e.t_wer >= 0) ? 64'd1 : 64'd0);
            chk({p, "_wem_count"}, 64'(m_cnt), (e.t_wem >= 0) ? 64'd1 : 64'd0);
            chk({p, "_pc"}, pc, pe);
            if (!e.ileg) begin
                chk({p, "_Ra"}, 64'(Ra), 64'(e.ra));
                chk({p, "_Rb"}, 64'(Rb), 64'(e.rb));
                chk({p, "_Rw"}, 64'(Rw), 64'(e.rw));
                chk({p, "_constante"}, constante, e.k);
                chk({p, "_entrada1"}, 64'(escolhe_entrada1), 64'(e.e1));
                chk({p, "_entrada2"}, 64'(escolhe_entrada2), 64'(ENT_B));
                chk({p, "_subtraindo"}, 64'(subtraindo), 64'(e.sub));
                chk({p, "_soma_ou_subtrai"}, 64'(soma_ou_subtrai), 64'd1);
                chk({p, "_sel_dinR"}, 64'(sel_dinR), 64'(e.dinm));
            end
        end
        @(negedge clk);
        chk({p, "_ready_back"}, 64'(instr_ready), 64'd1);
        chk({p, "_quiet_after"}, {60'd0, WeR, WeM, done, illegal}, 64'd0);
    endtask

    initial begin
        vecs[0] = mk(32'h00203103, 0, 5,  4, -1, 5'd2, 5'd0, 5'd2, 64'd2, ENT_C, 0, 1); // ld x2,2(x0)
        vecs[1] = mk(32'h001032A3, 0, 3, -1,  2, 5'd1, 5'd0, 5'd0, 64'd5, ENT_C, 0, 0); // sd x1,5(x0)
        vecs[2] = mk(32'h40208233, 0, 4,  3, -1, 5'd2, 5'd1, 5'd4, 64'd0, ENT_A, 1, 0); // sub x4,x1,x2
        vecs[3] = mk(32'hFE908293, 0, 4,  3, -1, 5'd9, 5'd1, 5'd5,
                     64'hFFFF_FFFF_FFFF_FFE9, ENT_C, 0, 0);                             // addi x5,x1,-23
        vecs[4] = mk(32'h00100013, 0, 4, -1, -1, 5'd1, 5'd0, 5'd0, 64'd1, ENT_C, 0, 0); // addi x0,x0,1
        vecs[5] = mk(32'h00208333, 0, 4,  3, -1, 5'd2, 5'd1, 5'd6, 64'd0, ENT_A, 0, 0); // add x6,x1,x2
        vecs[6] = mk(32'h00000000, 1, 2, -1, -1, 5'd0, 5'd0, 5'd0, 64'd0, ENT_B, 0, 0); // all-zero word
        vecs[7] = mk(32'h00202103, 1, 2, -1, -1, 5'd0, 5'd0, 5'd0, 64'd0, ENT_B, 0, 0); // lw (f3=010)
        vecs[8] = mk(32'h60208233, 1, 2, -1, -1, 5'd0, 5'd0, 5'd0, 64'd0, ENT_B, 0, 0); // bad f7

        for (int r = 0; r < 32; r++) begin
            regs[r] = '0;
            mem[r]  = '0;
        end
        regs[1] = 64'd7;
        mem[2]  = 64'd3;
        pc_exp  = '0;

        // Reset held with valid asserted: nothing may be accepted.
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instr       = 32'h00208333;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(instr_ready), 64'd1);
        chk("rst_pc", pc, 64'd0);
        chk("rst_pulses", {60'd0, WeR, WeM, done, illegal}, 64'd0);
        chk("rst_selects", {48'd0, Ra, Rb, Rw, escolhe_entrada1}, 64'd0);
        instr_valid = 1'b0;
        rst_n       = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 64'(instr_ready), 64'd1);
        chk("rst_release_pc", pc, 64'd0);

        for (int i = 0; i < 9; i++) run(i);

        // Reset while sd sits in EXECUTA: the WeM it would raise is dropped.
        instr       = 32'h001032A3;
        instr_valid = 1'b1;
        @(negedge clk);                 // handshake edge passed
        instr_valid = 1'b0;
        chk("abort_accepted", 64'(instr_ready), 64'd0);
        @(negedge clk);                 // now in EXECUTA
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_wem", 64'(WeM), 64'd0);
        chk("abort_pc", pc, 64'd0);
        chk("abort_ready", 64'(instr_ready), 64'd1);
        rst_n  = 1'b1;
        pc_exp = '0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", {60'd0, WeR, WeM, done, illegal}, 64'd0);
        end
        run(5);

        // Architectural state built from the DUT's control sequence.
        chk("x0", regs[0], 64'd0);
        chk("x2_loaded", regs[2], 64'd3);
        chk("mem5_stored", mem[5], 64'd7);
        chk("x4_sub", regs[4], 64'd4);
        chk("x5_addi", regs[5], 64'hFFFF_FFFF_FFFF_FFF0);
        chk("x6_add", regs[6], 64'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
Multi-cycle control unit for the RISC-V datapath (BancoRegistradores, MemoryData, ULA).
- Accepts one 32-bit instruction per handshake, decodes it, and sequences the datapath control signals that the bench currently hand-drives: register selects, write enables, constante, ULA mode and input selects.
- Supports ld, sd, add, sub and addi.
- Holds the PC.

Parameters:
XLEN, 64, datapath width (constante, pc)
PC_RESET, 0, pc value after reset
PC_STEP, 4, pc increment per retired or illegal instruction

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
instr_valid  in  1  instruction available
instr  in  32  RISC-V instruction word
instr_ready  out  1  unit idle, accepts instruction
Ra  out  5  register file read port a (store data / sub subtrahend / add operand)
Rb  out  5  register file read port b (base / rs1)
Rw  out  5  register file write index
WeR  out  1  register file write enable
WeM  out  1  data memory write enable
constante  out  XLEN  sign-extended immediate to the ULA
soma_ou_subtrai  out  1  ULA add/sub class select
subtraindo  out  1  1 = subtract
escolhe_entrada1  out  2  ULA input 1 select (B=0, A=1, C=2)
escolhe_entrada2  out  2  ULA input 2 select
sel_dinR  out  1  register file din source: 0 = doutULA, 1 = doutM
pc  out  XLEN  current instruction address
done  out  1  one-cycle pulse on retire
illegal  out  1  one-cycle pulse on unsupported encoding

Behaviour:
Outputs and reset:
- All outputs are registered.
- On rst_n=0 at a clk edge: state=OCIOSO, pc=PC_RESET, instr_ready=1, and every other output is 0.
- Reset mid-instruction aborts the instruction with no write enable asserted on the following edge.

ULA convention:
- Result = entrada2 + entrada1, or entrada2 - entrada1 when subtraindo=1.
- soma_ou_subtrai=1 for every supported op.

Decode:
- ld: opcode 0000011, f3 011.
- sd: opcode 0100011, f3 011.
- add: opcode 0110011, f3 000, f7 0000000.
- sub: opcode 0110011, f3 000, f7 0100000.
- addi: opcode 0010011, f3 000.
- Anything else is illegal.
- I/S immediates are sign-extended from 12 bits to XLEN.

States:
- OCIOSO: instr_ready=1. On instr_valid&instr_ready, latch instr, drop instr_ready, go to DECODIFICA. Ignore instr_valid while instr_ready=0.
- DECODIFICA: drive Rb=rs1, Ra=rs2, constante=imm (0 for R-type). Illegal encodings go to ERRO; otherwise go to EXECUTA.
- EXECUTA, selects per op:
  - ld: e1=C, e2=B.
  - sd: e1=C, e2=B.
  - add/sub: e1=A, e2=B.
  - addi: e1=C, e2=B.
  - subtraindo=1 only for sub.
  - Transitions: sd asserts WeM=1 this cycle, then goes to RETIRA. ld goes to MEMORIA. add/sub/addi go to ESCRITA.
- MEMORIA: hold selects one cycle to cover the memory read latency, set sel_dinR=1, go to ESCRITA.
- ESCRITA: Rw=rd; WeR=1 for exactly one cycle unless rd=0 (x0 is never written); selects held; go to RETIRA.
- RETIRA: done=1, pc += PC_STEP (wraps mod 2^XLEN), go to OCIOSO.
- ERRO: illegal=1, no WeR/WeM, pc += PC_STEP, go to OCIOSO.

Latency, with handshake accepted at edge T:
- add/sub/addi: done high in cycle T+4, instr_ready high at T+5.
- ld: one cycle longer than add.
- sd: WeM high at T+2, done at T+3.
- illegal: illegal at T+2.

Invariants:
- WeR and WeM are never high together.
- Each is never high for more than 1 cycle per instruction.

Decomposition:
- Package controle_pkg: opcode/funct constants; state enum (OCIOSO, DECODIFICA, EXECUTA, MEMORIA, ESCRITA, RETIRA, ERRO); ULA select codes ENT_B=0, ENT_A=1, ENT_C=2; op enum (OP_LD, OP_SD, OP_ADD, OP_SUB, OP_ADDI, OP_ILEGAL).
- Sub-module gerador_imediato: combinational I/S immediate extraction and sign extension to XLEN. The FSM stays in the top.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with instr_valid=1 -> instr_ready=1, pc=0, WeR=WeM=done=0; no instruction accepted while rst_n=0.
2. ld x2,2(x0) (0x00203103) -> Rb=0, constante=2, e1=C, e2=B, sel_dinR=1, Rw=2, WeR pulse at T+4, done at T+5, pc=4.
3. sd x1,5(x0) (0x001032A3) -> Ra=1, Rb=0, constante=5, WeM=1 only at T+2, WeR never high, done at T+3.
4. sub x4,x1,x2 (0x40208233) with x1=7, x2=3 on the datapath model -> Rb=1, Ra=2, subtraindo=1, e1=A, e2=B, Rw=4, x4=4.
5. addi x5,x1,-23 (0xFE908293) -> constante=0xFFFF_FFFF_FFFF_FFE9, subtraindo=0, e1=C, e2=B, WeR pulse, Rw=5.
6. Edge cases:
   - addi x0,x0,1 -> WeR stays 0, done pulses.
   - Word 0x00000000 -> illegal pulse at T+2, no writes, pc+=4.
   - rst_n=0 during EXECUTA of sd -> WeM=0 next cycle, pc=0.
